// File: rtl/n_bit_register_with_async_rst_sync_load.sv
// N-bit holding register: synchronous active-high reset, synchronous load.
// Ports: clk, rst (sync, active-high), load, d[N-1:0] in; q[N-1:0] out.
module n_bit_register_with_async_rst_sync_load #(
   parameter int unsigned  N       = 4,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] data_d;
   logic [N-1:0] data_q;

   // Ternary rather than if/else so an X on load propagates to q.
   always_comb begin
      data_d = data_q;
      data_d = load ? d : data_q;
   end

   // Despite the module name, reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) data_q <= RST_VAL;
      else     data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: tb/tb_n_bit_register_with_async_rst_sync_load.sv
// Bench for n_bit_register_with_async_rst_sync_load at N=4, N=1 and N=16.
// Reference model applies reset/load/hold priority directly per edge.
module tb_n_bit_register_with_async_rst_sync_load;

   localparam logic [3:0]  RV4  = 4'h0;
   localparam logic [0:0]  RV1  = 1'b0;
   localparam logic [15:0] RV16 = 16'hA5A5;

   logic        clk;
   logic        rst;
   logic        load;
   logic [3:0]  d4;
   logic [0:0]  d1;
   logic [15:0] d16;
   logic [3:0]  q4;
   logic [0:0]  q1;
   logic [15:0] q16;

   logic [15:0] m4;
   logic [15:0] m1;
   logic [15:0] m16;

   int tests;
   int fails;

   n_bit_register_with_async_rst_sync_load #(
      .N(4), .RST_VAL(RV4)
   ) u4 (
      .clk(clk), .rst(rst), .load(load), .d(d4), .q(q4)
   );

   n_bit_register_with_async_rst_sync_load #(
      .N(1), .RST_VAL(RV1)
   ) u1 (
      .clk(clk), .rst(rst), .load(load), .d(d1), .q(q1)
   );

   n_bit_register_with_async_rst_sync_load #(
      .N(16), .RST_VAL(RV16)
   ) u16 (
      .clk(clk), .rst(rst), .load(load), .d(d16), .q(q16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next stored value of a W-bit register: reset wins, then load, else hold.
   function automatic logic [15:0] nxt(
      input logic [15:0] cur,
      input logic        r,
      input logic        l,
      input logic [15:0] din,
      input logic [15:0] rv,
      input int          w
   );
      logic [15:0] mask;
      mask = 16'hFFFF >> (16 - w);
      if (r)      return rv & mask;
      else if (l) return din & mask;
      else        return cur;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "/n4"},  {12'h000, q4}, m4);
      check({tag, "/n1"},  {15'h0000, q1}, m1);
      check({tag, "/n16"}, q16, m16);
   endtask

   // Drive one set of inputs, take one edge, update model, compare.
   task automatic cyc(input string tag, input logic r, input logic l,
                      input logic [15:0] din);
      rst  = r;
      load = l;
      d16  = din;
      d4   = din[3:0];
      d1   = din[0:0];
      @(posedge clk);
      m4  = nxt(m4,  r, l, din, {12'h000, RV4}, 4);
      m1  = nxt(m1,  r, l, din, {15'h0000, RV1}, 1);
      m16 = nxt(m16, r, l, din, RV16, 16);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [15:0] rv;
      tests = 0;
      fails = 0;
      m4  = 'x;
      m1  = 'x;
      m16 = 'x;

      cyc("rst0", 1'b1, 1'b0, 16'h000A);
      cyc("rst1", 1'b1, 1'b0, 16'h000A);
      cyc("rst2", 1'b1, 1'b0, 16'h000A);

      cyc("rst_beats_load", 1'b1, 1'b1, 16'hFFFF);
      cyc("load_ff",        1'b0, 1'b1, 16'hFFFF);

      cyc("hold0", 1'b0, 1'b0, 16'h0003);
      cyc("hold1", 1'b0, 1'b0, 16'h0005);
      cyc("hold2", 1'b0, 1'b0, 16'h000C);

      d4  = 4'h6;
      d1  = 1'b0;
      d16 = 16'h6666;
      load = 1'b1;
      #2;
      check_all("mid_cycle_d");
      load = 1'b0;

      for (int i = 0; i < 10; i++) begin
         rv = 16'($urandom);
         cyc("stream", 1'b0, 1'b1, rv);
      end

      cyc("load_3",   1'b0, 1'b1, 16'h0003);
      cyc("mid_rst",  1'b1, 1'b1, 16'h0003);
      cyc("post_rst", 1'b0, 1'b1, 16'h0009);

      cyc("sw_rst",  1'b1, 1'b0, 16'h0000);
      cyc("sw_load", 1'b0, 1'b1, 16'h1234);
      cyc("sw_hold", 1'b0, 1'b0, 16'hBEEF);

      for (int i = 0; i < 40; i++) begin
         rv = 16'($urandom);
         cyc("rand", ($urandom_range(0, 7) == 0), 1'($urandom), rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
